brushless_commutator: RTL and testbench
=======================================

// Module: brushless_commutator
// PURPOSE
//  Parametrised successor to the six-step BLDC commutation block in the e-bike drive path.
//  Sits between the Hall inputs and the PWM/phase-driver stage.
//  Adds Hall glitch filtering, invalid-code fault detection, dead-time blanking, reverse
//  drive and registered duty. The phase drivers take sel*; the PWM generator takes duty.
// PARAMETERS
//  DRV_W     12  width of drv_mag; must be >= DUTY_W-1
//  DUTY_W    11  width of duty
//  FILT_CNT  3   consecutive equal PWM_synch samples required to accept a Hall code (>=1)
//  BLANK_CYC 16  clk cycles all coils HIGH_Z after each commutation (0 = no blanking)
//  PER_W     16  width of hall_period counter (HALL_PERIOD_EN only)
// PORTS
//  clk          in   1        system clock
//  rst_n        in   1        asynchronous active-low reset
//  drv_mag      in   DRV_W    requested drive magnitude
//  hallGrn/Ylw/Blu in 1 each  raw asynchronous Hall sensor inputs
//  brake_n      in   1        0 = regenerative brake request
//  reverse      in   1        1 = reverse rotation (for_curr/rev_curr swapped)
//  PWM_synch    in   1        1-clk pulse at PWM period start
//  duty         out  DUTY_W   PWM duty
//  selGrn/Ylw/Blu out 2 each  coil drive: 0 HIGH_Z, 1 rev_curr, 2 for_curr, 3 regen_braking
//  hall_fault   out  1        accepted Hall code is 000 or 111
//  commutate    out  1        1-clk pulse on each accepted valid-to-valid code change
//  hall_period  out  PER_W    clks between commutations (HALL_PERIOD_EN only)
// BEHAVIOUR
//  Reset: every output 0; accepted code 000; filter count 0; FSM RUN.
//  Hall path: 2-FF synchroniser per Hall input, bit order {G,Y,B}.
//  - Candidate code sampled on PWM_synch.
//  - Filter count increments while the candidate equals the previous sample, saturates at
//    FILT_CNT, and restarts at 1 when the candidate changes.
//  - At FILT_CNT, the candidate becomes the accepted code.
//  - Accept of 000/111 sets hall_fault; accept of any valid code clears it.
//  Forward table (G,Y,B):
//    101 F,R,Z   100 F,Z,R   110 Z,F,R   010 R,F,Z   011 R,Z,F   001 Z,R,F
//    reverse=1 swaps F<->R; Z is unchanged.
//  FSM (registered; sel* valid 1 clk after FSM/code update):
//  - RUN: sel* from table; 000/111 gives all HIGH_Z.
//  - RUN->BLANK on a valid-to-valid accepted code change (commutate pulses), or on a
//    reverse toggle. Skipped if BLANK_CYC=0.
//  - BLANK: all HIGH_Z for BLANK_CYC clks, then RUN using the newest code.
//  - A further code change during BLANK restarts the blank count and pulses commutate.
//  - Any state with brake_n=0 -> BRAKE next clk: all sel = 3. Brake overrides BLANK and fault.
//  - BRAKE with brake_n=1 -> BLANK, or RUN if BLANK_CYC=0.
//  - The filter keeps running in all states.
//  duty: registered and updated only on PWM_synch.
//  - Braking: 2^(DUTY_W-1) + 2^(DUTY_W-2), i.e. 0x600.
//  - Otherwise, hall_fault=1: 2^(DUTY_W-1).
//  - Otherwise: 2^(DUTY_W-1) + drv_mag[DRV_W-1 -: DUTY_W-1], i.e. 0x400 + drv_mag[11:2].
//  - Sum cannot overflow.
//  Simultaneous events: brake beats code change.
//  - A code change in the same clk as brake entry still pulses commutate.
//  - An async reset mid-BLANK returns immediately to reset values.
// CONFIGURATION
//  HALL_PERIOD_EN defined:
//  - Counter counts clks, saturating at 2^PER_W-1.
//  - On commutate: hall_period <= counter, counter <= 1.
//  - On saturation: hall_period <= all-ones (stall indication).
//  HALL_PERIOD_EN undefined: port hall_period absent and no counter logic is built.
// TESTING
//  1. Defaults; step Halls through 101,100,110,010,011,001, each held 4 PWM_synch.
//     -> 6 commutate pulses, 16-clk all-Z gaps, table sel values.
//  2. reverse=1 and code 101 -> selGrn=1, selYlw=2, selBlu=0. Toggling reverse -> 16-clk blank.
//  3. A 2-PWM_synch glitch 101->100->101 -> no accept, no commutate, sel unchanged.
//  4. Hold 111 for 3 PWM_synch -> hall_fault=1, sel all 0, duty=0x400 next PWM_synch.
//     Then 101 -> fault clears.
//  5. brake_n=0 mid-BLANK -> sel all 3 next clk; duty=0x600 at next PWM_synch.
//     Release -> blank, then RUN.
//  6. drv_mag=0xFFF, brake_n=1 -> duty=0x7FF. With HALL_PERIOD_EN: commutations 1000 clks
//     apart -> hall_period=1000. No edges for 65535 clks -> 0xFFFF.

Source files
------------

// File: rtl/brushless_commutator.sv
// Six-step BLDC commutator: filtered Hall decode, dead-time blanking, reverse drive, braking, registered duty.
// Latency: Hall pin -> accepted code = 2 sync clks + FILT_CNT PWM_synch samples; sel* registered 1 clk after state/code.
// Backpressure: none; free-running control path, outputs are level-held registers.
// Ports: clk/rst_n; drv_mag, hallGrn/Ylw/Blu, brake_n, reverse, PWM_synch in;
//        duty, selGrn/Ylw/Blu (0 HIGH_Z, 1 rev_curr, 2 for_curr, 3 regen), hall_fault, commutate out.
// Optional: define HALL_PERIOD_EN to add the PER_W parameter, the hall_period port and its counter.
module brushless_commutator #(
  parameter int DRV_W     = 12,
  parameter int DUTY_W    = 11,
  parameter int FILT_CNT  = 3,
  parameter int BLANK_CYC = 16
`ifdef HALL_PERIOD_EN
  ,
  parameter int PER_W     = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DRV_W-1:0]  drv_mag,
  input  logic              hallGrn,
  input  logic              hallYlw,
  input  logic              hallBlu,
  input  logic              brake_n,
  input  logic              reverse,
  input  logic              PWM_synch,
  output logic [DUTY_W-1:0] duty,
  output logic [1:0]        selGrn,
  output logic [1:0]        selYlw,
  output logic [1:0]        selBlu,
  output logic              hall_fault,
  output logic              commutate
`ifdef HALL_PERIOD_EN
  ,
  output logic [PER_W-1:0]  hall_period
`endif
);

  localparam int FC_W = $clog2(FILT_CNT + 1);
  localparam logic [FC_W-1:0] FiltMax = FC_W'(FILT_CNT);
  localparam logic [FC_W-1:0] FiltOne = FC_W'(1);
  localparam int BC_W = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BC_W-1:0] BlankLoad = BC_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam bit HasBlank = (BLANK_CYC > 0);
  localparam logic [DUTY_W-1:0] DutyHalf  = {1'b1, {(DUTY_W-1){1'b0}}};
  localparam logic [DUTY_W-1:0] DutyBrake = {2'b11, {(DUTY_W-2){1'b0}}};

  typedef enum logic [1:0] {StRun = 2'd0, StBlank = 2'd1, StBrake = 2'd2} state_t;

  function automatic logic codeValid(input logic [2:0] c);
    return (c != 3'b000) && (c != 3'b111);
  endfunction

  // Forward six-step table, packed {G,Y,B}; reverse swaps for_curr/rev_curr per coil.
  function automatic logic [5:0] driveTable(input logic [2:0] c, input logic rev);
    logic [5:0] f;
    case (c)
      3'b101:  f = 6'b10_01_00;
      3'b100:  f = 6'b10_00_01;
      3'b110:  f = 6'b00_10_01;
      3'b010:  f = 6'b01_10_00;
      3'b011:  f = 6'b01_00_10;
      3'b001:  f = 6'b00_01_10;
      default: f = 6'b00_00_00;
    endcase
    if (rev) f = {f[4], f[5], f[2], f[3], f[0], f[1]};
    return f;
  endfunction

  logic [2:0]      hallMeta, hallSync, prevSample, acceptedCode;
  logic [FC_W-1:0] filtCnt, filtCntNext;
  logic [BC_W-1:0] blankCnt;
  logic            acceptNow, commuteEvt, revPrev, revToggle, loadBlank;
  logic [5:0]      selNext;
  state_t          state, stateNext;

  // Two-flop synchroniser, bit order {G,Y,B}
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hallMeta <= '0;
      hallSync <= '0;
    end else begin
      hallMeta <= {hallGrn, hallYlw, hallBlu};
      hallSync <= hallMeta;
    end
  end

  always_comb begin
    if (hallSync != prevSample)   filtCntNext = FiltOne;
    else if (filtCnt == FiltMax)  filtCntNext = filtCnt;
    else                          filtCntNext = filtCnt + FiltOne;
  end

  // Re-accepting the current code is harmless: commuteEvt needs an actual change.
  assign acceptNow  = PWM_synch && (filtCntNext == FiltMax);
  assign commuteEvt = acceptNow && codeValid(hallSync) && codeValid(acceptedCode) &&
                      (hallSync != acceptedCode);
  assign revToggle  = reverse ^ revPrev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prevSample   <= '0;
      filtCnt      <= '0;
      acceptedCode <= '0;
      hall_fault   <= 1'b0;
      commutate    <= 1'b0;
      revPrev      <= 1'b0;
    end else begin
      if (PWM_synch) begin
        prevSample <= hallSync;
        filtCnt    <= filtCntNext;
      end
      if (acceptNow) begin
        acceptedCode <= hallSync;
        hall_fault   <= !codeValid(hallSync);
      end
      commutate <= commuteEvt;
      revPrev   <= reverse;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= StRun;
    else        state <= stateNext;
  end

  // FSM: next state; brake wins over everything else
  always_comb begin
    stateNext = state;
    case (state)
      StRun:   if (HasBlank && (commuteEvt || revToggle)) stateNext = StBlank;
      StBlank: if (!(commuteEvt || revToggle) && (blankCnt == '0)) stateNext = StRun;
      StBrake: stateNext = HasBlank ? StBlank : StRun;
      default: stateNext = StRun;
    endcase
    if (!brake_n) stateNext = StBrake;
  end

  // FSM: outputs. revPrev (not reverse) keeps the old polarity until the blank takes over.
  always_comb begin
    selNext = 6'b00_00_00;
    case (state)
      StRun:   selNext = driveTable(acceptedCode, revPrev);
      StBrake: selNext = 6'b11_11_11;
      default: selNext = 6'b00_00_00;
    endcase
  end

  // Blank counter reloads on entry and on every further commutation/reverse toggle.
  assign loadBlank = (stateNext == StBlank) &&
                     ((state != StBlank) || commuteEvt || revToggle);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blankCnt <= '0;
    end else if (loadBlank) begin
      blankCnt <= BlankLoad;
    end else if ((state == StBlank) && (blankCnt != '0)) begin
      blankCnt <= blankCnt - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {selGrn, selYlw, selBlu} <= '0;
      duty                     <= '0;
    end else begin
      {selGrn, selYlw, selBlu} <= selNext;
      if (PWM_synch) begin
        if (state == StBrake) duty <= DutyBrake;
        else if (hall_fault)  duty <= DutyHalf;
        else                  duty <= DutyHalf + {1'b0, drv_mag[DRV_W-1 -: DUTY_W-1]};
      end
    end
  end

  // Low drv_mag bits below duty resolution are intentionally dropped.
  if (DRV_W > DUTY_W - 1) begin : gDrvLsbs
    logic unusedDrvLsbs;
    assign unusedDrvLsbs = ^drv_mag[DRV_W-DUTY_W:0];
  end

`ifdef HALL_PERIOD_EN
  logic [PER_W-1:0] perCnt;

  // hall_period latches the interval at each commutation; a saturated counter means stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perCnt      <= '0;
      hall_period <= '0;
    end else if (commuteEvt) begin
      hall_period <= perCnt;
      perCnt      <= PER_W'(1);
    end else if (perCnt != '1) begin
      perCnt <= perCnt + PER_W'(1);
    end else begin
      hall_period <= '1;
    end
  end
`endif

endmodule

// File: tb/tb_brushless_commutator.sv
// Directed bench for brushless_commutator: six-step table, blanking, reverse, glitch filter,
// fault, brake, duty scaling, async reset; hall_period checks when HALL_PERIOD_EN is defined.
// Inputs change just after the falling edge; outputs are read 1ns after the falling edge.
module tb_brushless_commutator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] drv_mag;
  logic        hallGrn, hallYlw, hallBlu, brake_n, reverse, PWM_synch;
  logic [10:0] duty;
  logic [1:0]  selGrn, selYlw, selBlu;
  logic        hall_fault, commutate;
`ifdef HALL_PERIOD_EN
  logic [15:0] hall_period;
`endif
  logic [5:0]  selAll;

  int errors = 0;
  int checks = 0;
  int commutCount = 0;
  int zTotal = 0;
  int zRun = 0;
  int lastGap = 0;

  always #5 clk = ~clk;
  assign selAll = {selGrn, selYlw, selBlu};

  brushless_commutator dut (
    .clk(clk), .rst_n(rst_n), .drv_mag(drv_mag),
    .hallGrn(hallGrn), .hallYlw(hallYlw), .hallBlu(hallBlu),
    .brake_n(brake_n), .reverse(reverse), .PWM_synch(PWM_synch),
    .duty(duty), .selGrn(selGrn), .selYlw(selYlw), .selBlu(selBlu),
    .hall_fault(hall_fault), .commutate(commutate)
`ifdef HALL_PERIOD_EN
    , .hall_period(hall_period)
`endif
  );

  // Measurement only: commutate pulse samples and length of all-HIGH_Z runs.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (commutate === 1'b1) commutCount++;
      if (selAll === 6'b0) begin
        zTotal++;
        zRun++;
      end else begin
        if (zRun != 0) lastGap = zRun;
        zRun = 0;
      end
    end
  end

  task automatic setHall(input logic [2:0] c);
    {hallGrn, hallYlw, hallBlu} = c;
  endtask

  // n PWM_synch pulses, one every 8 clks
  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (7) @(negedge clk);
      PWM_synch = 1'b1;
      @(negedge clk);
      PWM_synch = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; drv_mag = 12'h123; brake_n = 1'b1; reverse = 1'b0; PWM_synch = 1'b0;
    setHall(3'b101);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (duty !== 11'h000) begin errors++; $display("FAIL reset_duty: got %h want 000", duty); end
    checks++; if (selAll !== 6'b0) begin errors++; $display("FAIL reset_sel: got %b want 000000", selAll); end
    checks++; if ({hall_fault, commutate} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {hall_fault, commutate}); end
    rst_n = 1'b1;
  endtask

  task automatic test_six_step;
    logic [2:0] codes [6];
    logic [5:0] exps  [6];
    codes = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
    exps  = '{6'b10_01_00, 6'b10_00_01, 6'b00_10_01, 6'b01_10_00, 6'b01_00_10, 6'b00_01_10};
    pulses(4);
    repeat (3) @(negedge clk);
    #1;
    checks++; if (selAll !== exps[0]) begin errors++; $display("FAIL first_accept_sel: got %b want %b", selAll, exps[0]); end
    checks++; if (duty !== 11'h448) begin errors++; $display("FAIL run_duty: got %h want 448", duty); end
    checks++; if (commutCount !== 0) begin errors++; $display("FAIL first_accept_commut: got %0d want 0", commutCount); end
    for (int i = 1; i < 6; i++) begin
      setHall(codes[i]);
      pulses(4);
      repeat (20) @(negedge clk);
      #1;
      checks++; if (selAll !== exps[i]) begin errors++; $display("FAIL step%0d_sel: got %b want %b", i, selAll, exps[i]); end
      checks++; if (lastGap !== 16) begin errors++; $display("FAIL step%0d_gap: got %0d want 16", i, lastGap); end
      checks++; if (commutCount !== i) begin errors++; $display("FAIL step%0d_commut: got %0d want %0d", i, commutCount, i); end
    end
  endtask

  task automatic test_reverse;
    setHall(3'b101);
    pulses(4);
    repeat (20) @(negedge clk);
    reverse = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    checks++; if (selAll !== 6'b01_10_00) begin errors++; $display("FAIL rev_sel: got %b want 011000", selAll); end
    checks++; if (lastGap !== 16) begin errors++; $display("FAIL rev_gap: got %0d want 16", lastGap); end
    checks++; if (commutCount !== 6) begin errors++; $display("FAIL rev_commut: got %0d want 6", commutCount); end
    reverse = 1'b0;
    repeat (25) @(negedge clk);
    #1;
    checks++; if (selAll !== 6'b10_01_00) begin errors++; $display("FAIL unrev_sel: got %b want 100100", selAll); end
  endtask

  task automatic test_glitch;
    int zBefore;
    zBefore = zTotal;
    setHall(3'b100);
    pulses(2);
    setHall(3'b101);
    pulses(4);
    #1;
    checks++; if (commutCount !== 6) begin errors++; $display("FAIL glitch_commut: got %0d want 6", commutCount); end
    checks++; if (selAll !== 6'b10_01_00) begin errors++; $display("FAIL glitch_sel: got %b want 100100", selAll); end
    checks++; if (zTotal - zBefore !== 0) begin errors++; $display("FAIL glitch_blank: got %0d Z clks want 0", zTotal - zBefore); end
  endtask

  task automatic test_fault;
    setHall(3'b111);
    pulses(3);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (hall_fault !== 1'b1) begin errors++; $display("FAIL fault_set: got %b want 1", hall_fault); end
    checks++; if (selAll !== 6'b0) begin errors++; $display("FAIL fault_sel: got %b want 000000", selAll); end
    pulses(1);
    #1;
    checks++; if (duty !== 11'h400) begin errors++; $display("FAIL fault_duty: got %h want 400", duty); end
    setHall(3'b101);
    pulses(3);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (hall_fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b want 0", hall_fault); end
    checks++; if (selAll !== 6'b10_01_00) begin errors++; $display("FAIL fault_recover_sel: got %b want 100100", selAll); end
    checks++; if (commutCount !== 6) begin errors++; $display("FAIL fault_commut: got %0d want 6", commutCount); end
    pulses(1);
    #1;
    checks++; if (duty !== 11'h448) begin errors++; $display("FAIL fault_recover_duty: got %h want 448", duty); end
  endtask

  task automatic test_brake;
    setHall(3'b100);
    pulses(3);
    repeat (4) @(negedge clk);
    #1;
    checks++; if (selAll !== 6'b0) begin errors++; $display("FAIL brake_pre_blank: got %b want 000000", selAll); end
    brake_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (selAll !== 6'b11_11_11) begin errors++; $display("FAIL brake_sel: got %b want 111111", selAll); end
    pulses(1);
    #1;
    checks++; if (duty !== 11'h600) begin errors++; $display("FAIL brake_duty: got %h want 600", duty); end
    brake_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (selAll !== 6'b0) begin errors++; $display("FAIL brake_release_blank: got %b want 000000", selAll); end
    repeat (20) @(negedge clk);
    #1;
    checks++; if (selAll !== 6'b10_00_01) begin errors++; $display("FAIL brake_release_run: got %b want 100001", selAll); end
    checks++; if (lastGap !== 16) begin errors++; $display("FAIL brake_release_gap: got %0d want 16", lastGap); end
    checks++; if (commutCount !== 7) begin errors++; $display("FAIL brake_commut: got %0d want 7", commutCount); end
  endtask

  task automatic test_drive_mag;
    drv_mag = 12'hFFF;
    pulses(1);
    #1;
    checks++; if (duty !== 11'h7FF) begin errors++; $display("FAIL duty_max: got %h want 7ff", duty); end
    drv_mag = 12'h000;
    pulses(1);
    #1;
    checks++; if (duty !== 11'h400) begin errors++; $display("FAIL duty_zero: got %h want 400", duty); end
    drv_mag = 12'h123;
  endtask

  // Brake request lands on the same clk as an accepted code change.
  task automatic test_brake_with_change;
    setHall(3'b101);
    pulses(2);
    repeat (7) @(negedge clk);
    PWM_synch = 1'b1;
    brake_n = 1'b0;
    @(negedge clk);
    PWM_synch = 1'b0;
    #1;
    checks++; if (commutCount !== 8) begin errors++; $display("FAIL brake_change_commut: got %0d want 8", commutCount); end
    @(negedge clk);
    #1;
    checks++; if (selAll !== 6'b11_11_11) begin errors++; $display("FAIL brake_change_sel: got %b want 111111", selAll); end
    brake_n = 1'b1;
    repeat (25) @(negedge clk);
    #1;
    checks++; if (selAll !== 6'b10_01_00) begin errors++; $display("FAIL brake_change_run: got %b want 100100", selAll); end
  endtask

`ifdef HALL_PERIOD_EN
  task automatic test_hall_period;
    setHall(3'b100);
    pulses(125);
    setHall(3'b101);
    pulses(125);
    #1;
    checks++; if (hall_period !== 16'd1000) begin errors++; $display("FAIL period_1000: got %0d want 1000", hall_period); end
    repeat (65600) @(negedge clk);
    #1;
    checks++; if (hall_period !== 16'hFFFF) begin errors++; $display("FAIL period_stall: got %h want ffff", hall_period); end
  endtask
`endif

  task automatic test_async_reset;
    int cBefore;
    setHall(3'b100);
    pulses(3);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (duty !== 11'h000) begin errors++; $display("FAIL arst_duty: got %h want 000", duty); end
    checks++; if ({hall_fault, commutate, selAll} !== 8'b0) begin errors++; $display("FAIL arst_outs: got %b want 00000000", {hall_fault, commutate, selAll}); end
    @(negedge clk);
    rst_n = 1'b1;
    cBefore = commutCount;
    pulses(3);
    repeat (2) @(negedge clk);
    #1;
    checks++; if (selAll !== 6'b10_00_01) begin errors++; $display("FAIL arst_run_sel: got %b want 100001", selAll); end
    checks++; if (commutCount - cBefore !== 0) begin errors++; $display("FAIL arst_commut: got %0d want 0", commutCount - cBefore); end
  endtask

  initial begin
    test_reset();
    test_six_step();
    test_reverse();
    test_glitch();
    test_fault();
    test_brake();
    test_drive_mag();
    test_brake_with_change();
`ifdef HALL_PERIOD_EN
    test_hall_period();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
